// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the burst-mode FFT frame sequencer.
package fft_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONFIG,
    LOAD,
    COMPUTE,
    UNLOAD,
    DRAIN
  } state_t;

  localparam int NFFT_LOG2_DEF = 7;

  function automatic int n_pts(input int log2);
    return 1 << log2;
  endfunction

  localparam int N = n_pts(NFFT_LOG2_DEF);

  // Core direction encoding: fft_fwd_inv=1 selects the forward transform.
  localparam logic FWD = 1'b1;

endpackage

// File: rtl/fft_idx_counter.sv
// Wrapping sample/bin index counter with synchronous clear and a terminal-count flag.
module fft_idx_counter
  import fft_ctrl_pkg::*;
#(
  parameter int W = NFFT_LOG2_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = &cnt;

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the burst-mode FFT core: configure, load, compute, unload, drain.
// Optional watchdog in COMPUTE/DRAIN is enabled with the FFT_TIMEOUT_EN macro.
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int NFFT_LOG2   = NFFT_LOG2_DEF,
  parameter int IN_W        = 16,
  parameter int OUT_W       = 24,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_inv,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in_re,
  input  logic [IN_W-1:0]      in_im,
  output logic                 out_valid,
  output logic                 out_last,
  output logic [NFFT_LOG2-1:0] out_index,
  output logic [OUT_W-1:0]     out_re,
  output logic [OUT_W-1:0]     out_im,
  output logic                 frame_done,
  output logic                 underrun,
  output logic                 timeout,
  output logic                 fft_start,
  output logic                 fft_unload,
  output logic                 fft_fwd_inv,
  output logic                 fft_fwd_inv_we,
  output logic [IN_W-1:0]      fft_xn_re,
  output logic [IN_W-1:0]      fft_xn_im,
  input  logic                 fft_rfd,
  input  logic                 fft_busy,
  input  logic                 fft_done,
  input  logic                 fft_edone,
  input  logic                 fft_dv,
  input  logic [NFFT_LOG2-1:0] fft_xn_index,
  input  logic [NFFT_LOG2-1:0] fft_xk_index,
  input  logic [OUT_W-1:0]     fft_xk_re,
  input  logic [OUT_W-1:0]     fft_xk_im
);

  state_t state_q, state_d;
  logic   inv_q, run_q, cfg_q;
  logic   cmd_acc, ld_en, dr_en, ld_tc, dr_tc, wd_hit;
  logic [NFFT_LOG2-1:0] ld_cnt, dr_cnt;

  // run_q keeps cmd_ready low while reset is held, since the core itself is never reset.
  assign cmd_ready = run_q && (state_q == IDLE) && !fft_busy;
  assign cmd_acc   = cmd_valid && cmd_ready;
  assign ld_en     = (state_q == LOAD) && fft_rfd;
  assign dr_en     = (state_q == DRAIN) && fft_dv && !wd_hit;

  fft_idx_counter #(.W(NFFT_LOG2)) u_ld_cnt (
    .clk(clk), .rst_n(rst_n), .clr(state_q == CONFIG), .en(ld_en), .cnt(ld_cnt), .tc(ld_tc)
  );

  fft_idx_counter #(.W(NFFT_LOG2)) u_dr_cnt (
    .clk(clk), .rst_n(rst_n), .clr(state_q == UNLOAD), .en(dr_en), .cnt(dr_cnt), .tc(dr_tc)
  );

  always_comb begin
    state_d        = state_q;
    fft_start      = 1'b0;
    fft_unload     = 1'b0;
    fft_fwd_inv    = 1'b0;
    fft_fwd_inv_we = 1'b0;
    in_ready       = 1'b0;
    fft_xn_re      = '0;
    fft_xn_im      = '0;
    case (state_q)
      IDLE:    if (cmd_acc) state_d = CONFIG;
      CONFIG: begin
        fft_fwd_inv_we = 1'b1;
        fft_fwd_inv    = inv_q ? !FWD : FWD;
        state_d        = LOAD;
      end
      LOAD: begin
        fft_start = cfg_q;
        in_ready  = fft_rfd;
        if (fft_rfd && in_valid) begin
          fft_xn_re = in_re;
          fft_xn_im = in_im;
        end
        if (ld_en && ld_tc) state_d = COMPUTE;
      end
      COMPUTE: begin
        if (wd_hit)        state_d = IDLE;
        else if (fft_done) state_d = UNLOAD;
      end
      UNLOAD: begin
        fft_unload = 1'b1;
        state_d    = DRAIN;
      end
      DRAIN:   if (wd_hit || out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      inv_q      <= 1'b0;
      run_q      <= 1'b0;
      cfg_q      <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_index  <= '0;
      out_re     <= '0;
      out_im     <= '0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      cfg_q     <= (state_q == CONFIG);
      out_valid <= dr_en;
      out_last  <= dr_en && dr_tc;
      if (dr_en) begin
        out_index <= fft_xk_index;
        out_re    <= fft_xk_re;
        out_im    <= fft_xk_im;
      end
      frame_done <= (state_q == DRAIN) && out_last && !wd_hit;
      if (cmd_acc) begin
        inv_q    <= cmd_inv;
        underrun <= 1'b0;
      end else if (ld_en && !in_valid) begin
        underrun <= 1'b1;
      end
    end
  end

`ifdef FFT_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  assign wd_hit  = ((state_q == COMPUTE) || (state_q == DRAIN)) && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
  assign timeout = timeout_q || wd_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_d != state_q)                          wd_cnt <= '0;
      else if (state_q == COMPUTE || state_q == DRAIN) wd_cnt <= wd_cnt + 1'b1;
      if (cmd_acc)     timeout_q <= 1'b0;
      else if (wd_hit) timeout_q <= 1'b1;
    end
  end
`else
  localparam int unused_tcyc = TIMEOUT_CYC;
  assign wd_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  logic unused_sig;
  assign unused_sig = &{1'b0, fft_edone, fft_xn_index, ld_cnt, dr_cnt};

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with a behavioural burst-mode FFT core model.
module tb_fft_frame_ctrl;

`ifdef FFT_TIMEOUT_EN
  localparam int TB_TCYC = 256;
`else
  localparam int TB_TCYC = 4096;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_inv = 1'b0, in_valid = 1'b0;
  logic [15:0] in_re = '0, in_im = '0;
  logic cmd_ready, in_ready, out_valid, out_last, frame_done, underrun, timeout;
  logic [6:0]  out_index;
  logic [23:0] out_re, out_im;
  logic fft_start, fft_unload, fft_fwd_inv, fft_fwd_inv_we;
  logic [15:0] fft_xn_re, fft_xn_im;

  // core model state
  logic fft_rfd = 1'b0, fft_busy = 1'b0, fft_done = 1'b0, fft_dv = 1'b0;
  logic fft_edone;
  logic [6:0]  fft_xn_index = '0, fft_xk_index = '0;
  logic [23:0] fft_xk_re = '0, fft_xk_im = '0;
  logic [23:0] sum_re = '0, sum_im = '0;
  logic [15:0] cap_re [128];
  logic        m_fwd = 1'b1;
  logic        abort_req = 1'b0, never_done = 1'b0;
  int          calc_cnt = 0, stuck_cnt = 0;
  typedef enum {M_IDLE, M_LOAD, M_CALC, M_WAIT, M_OUT, M_STUCK} m_t;
  m_t m_st = M_IDLE;

  assign fft_edone = 1'b0;

  always #5 clk = ~clk;

  fft_frame_ctrl #(.NFFT_LOG2(7), .IN_W(16), .OUT_W(24), .TIMEOUT_CYC(TB_TCYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_inv(cmd_inv),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_last(out_last), .out_index(out_index),
    .out_re(out_re), .out_im(out_im),
    .frame_done(frame_done), .underrun(underrun), .timeout(timeout),
    .fft_start(fft_start), .fft_unload(fft_unload),
    .fft_fwd_inv(fft_fwd_inv), .fft_fwd_inv_we(fft_fwd_inv_we),
    .fft_xn_re(fft_xn_re), .fft_xn_im(fft_xn_im),
    .fft_rfd(fft_rfd), .fft_busy(fft_busy), .fft_done(fft_done),
    .fft_edone(fft_edone), .fft_dv(fft_dv),
    .fft_xn_index(fft_xn_index), .fft_xk_index(fft_xk_index),
    .fft_xk_re(fft_xk_re), .fft_xk_im(fft_xk_im)
  );

  // Model output: bin 0 is the DC sum, other bins carry a direction-dependent marker.
  function automatic logic [23:0] bin_re(input int k, input logic [23:0] s, input logic f);
    if (k == 0) return s;
    return f ? 24'(k) : 24'(1000 + k);
  endfunction

  always @(posedge clk) begin
    fft_done <= 1'b0;
    if (fft_fwd_inv_we) m_fwd <= fft_fwd_inv;
    if (abort_req) begin
      m_st <= M_STUCK; stuck_cnt <= 49;
      fft_rfd <= 1'b0; fft_dv <= 1'b0; fft_busy <= 1'b1;
    end else begin
      case (m_st)
        M_IDLE: if (fft_start) begin
          m_st <= M_LOAD; fft_rfd <= 1'b1; fft_busy <= 1'b1;
          fft_xn_index <= '0; sum_re <= '0; sum_im <= '0;
        end
        M_LOAD: begin
          cap_re[fft_xn_index] <= fft_xn_re;
          sum_re <= sum_re + {8'd0, fft_xn_re};
          sum_im <= sum_im + {8'd0, fft_xn_im};
          if (fft_xn_index == 7'd127) begin
            fft_rfd <= 1'b0; m_st <= M_CALC; calc_cnt <= 10;
          end else fft_xn_index <= fft_xn_index + 7'd1;
        end
        M_CALC: if (!never_done) begin
          if (calc_cnt == 0) begin fft_done <= 1'b1; fft_busy <= 1'b0; m_st <= M_WAIT; end
          else calc_cnt <= calc_cnt - 1;
        end
        M_WAIT: if (fft_unload) begin
          m_st <= M_OUT; fft_dv <= 1'b1; fft_xk_index <= '0;
          fft_xk_re <= bin_re(0, sum_re, m_fwd); fft_xk_im <= sum_im;
        end
        M_OUT: begin
          if (fft_xk_index == 7'd127) begin
            fft_dv <= 1'b0; m_st <= M_IDLE;
          end else begin
            fft_xk_index <= fft_xk_index + 7'd1;
            fft_xk_re <= bin_re(int'(fft_xk_index) + 1, sum_re, m_fwd);
            fft_xk_im <= 24'(2 * (int'(fft_xk_index) + 1));
          end
        end
        M_STUCK: begin
          if (stuck_cnt == 0) begin fft_busy <= 1'b0; m_st <= M_IDLE; end
          else stuck_cnt <= stuck_cnt - 1;
        end
        default: m_st <= M_IDLE;
      endcase
    end
  end

  // Activity monitor, sampled 1 time unit after each rising edge.
  int cyc = 0, n_inrdy = 0, n_start = 0, n_we = 0, n_unload = 0, n_done = 0, n_beats = 0;
  int idx_err = 0, unload_gap = -1, done_cyc = 0, last_inrdy_cyc = 0, to_cyc = 0;
  logic [23:0] dc_seen = '0, exp_dc = 24'd128;
  logic [6:0]  last_idx = '0;
  logic        we_val = 1'b0, exp_fwd = 1'b1, to_seen = 1'b0;

  always begin
    @(posedge clk); #1;
    cyc++;
    if (in_ready) begin n_inrdy++; last_inrdy_cyc = cyc; end
    if (fft_start) n_start++;
    if (fft_fwd_inv_we) begin n_we++; we_val = fft_fwd_inv; end
    if (fft_done) done_cyc = cyc;
    if (fft_unload) begin n_unload++; unload_gap = cyc - done_cyc; end
    if (frame_done) n_done++;
    if (timeout && !to_seen) begin to_seen = 1'b1; to_cyc = cyc; end
    if (out_valid) begin
      if (int'(out_index) != (n_beats % 128)) idx_err++;
      if (out_index == 7'd0) begin
        dc_seen = out_re;
        if (out_re !== exp_dc || out_im !== 24'd0) idx_err++;
      end else begin
        if (out_re !== (exp_fwd ? 24'(out_index) : 24'(1000 + int'(out_index)))) idx_err++;
        if (out_im !== 24'(2 * int'(out_index))) idx_err++;
      end
      if (out_last !== (out_index == 7'd127)) idx_err++;
      if (out_last) last_idx = out_index;
      n_beats++;
    end
  end

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int outs_ones();
    return $countones({cmd_ready, in_ready, out_valid, out_last, out_index, out_re, out_im,
                       frame_done, underrun, timeout, fft_start, fft_unload, fft_fwd_inv,
                       fft_fwd_inv_we, fft_xn_re, fft_xn_im});
  endfunction

  // Issues one command and feeds samples until frame_done; optionally drops
  // samples 40-42 and pokes cmd_valid once in DRAIN.
  task automatic run_frame(input logic inv, input bit gap, input bit poke, input string tag);
    int b0, d0, i0, w0, s0, u0;
    bit poked;
    b0 = n_beats; d0 = n_done; i0 = n_inrdy; w0 = n_we; s0 = n_start; u0 = n_unload;
    poked = 1'b0;
    exp_fwd = !inv;
    for (int c = 0; c < 200 && !cmd_ready; c++) @(negedge clk);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_inv = inv;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c < 2000 && n_done == d0; c++) begin
      in_re = 16'd1; in_im = 16'd0;
      in_valid = !(gap && fft_xn_index >= 7'd40 && fft_xn_index <= 7'd42);
      cmd_valid = 1'b0;
      if (poke && !poked && (n_beats - b0) == 10) begin
        poked = 1'b1; cmd_valid = 1'b1;
        chk({tag, "_drain_cmd_ready"}, cmd_ready, 0);
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0; in_valid = 1'b0;
    chk({tag, "_frame_done"}, n_done - d0, 1);
    chk({tag, "_beats"}, n_beats - b0, 128);
    chk({tag, "_in_ready_cycles"}, n_inrdy - i0, 128);
    chk({tag, "_we_pulses"}, n_we - w0, 1);
    chk({tag, "_fwd_inv"}, we_val, !inv);
    chk({tag, "_start_pulses"}, n_start - s0, 1);
    chk({tag, "_unload_pulses"}, n_unload - u0, 1);
    chk({tag, "_unload_gap"}, unload_gap, 1);
    chk({tag, "_last_idx"}, last_idx, 127);
    chk({tag, "_dc"}, dc_seen, exp_dc);
    chk({tag, "_beat_errors"}, idx_err, 0);
  endtask

  initial begin
    int bad, d0, b0;
    // 1: reset
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_outputs", outs_ones(), 0);
    rst_n = 1'b1;
    chk("reset_release_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    chk("cmd_ready_after_reset", cmd_ready, 1);

    // 2: forward frame, DC of 128 ones
    exp_dc = 24'd128;
    run_frame(1'b0, 1'b0, 1'b0, "fwd");
    chk("fwd_underrun", underrun, 0);

    // 3: underrun at samples 40-42
    exp_dc = 24'd125;
    run_frame(1'b0, 1'b1, 1'b0, "gap");
    chk("gap_underrun", underrun, 1);
    chk("gap_xn39", cap_re[39], 1);
    chk("gap_xn40", cap_re[40], 0);
    chk("gap_xn41", cap_re[41], 0);
    chk("gap_xn42", cap_re[42], 0);
    chk("gap_xn43", cap_re[43], 1);

    // 4: inverse straight after frame_done, with a cmd_valid poke in DRAIN
    exp_dc = 24'd128;
    run_frame(1'b1, 1'b0, 1'b1, "inv");
    chk("inv_underrun_cleared", underrun, 0);
    chk("timeout_idle", timeout, 0);

    // 5: reset at load sample 64 with the core left busy
    d0 = n_done; b0 = n_beats;
    for (int c = 0; c < 200 && !cmd_ready; c++) @(negedge clk);
    cmd_valid = 1'b1; cmd_inv = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0; in_valid = 1'b1; in_re = 16'd1;
    for (int c = 0; c < 300 && !(in_ready && fft_xn_index == 7'd64); c++) @(negedge clk);
    chk("abort_reached_64", fft_xn_index, 64);
    rst_n = 1'b0; abort_req = 1'b1;
    @(negedge clk);
    abort_req = 1'b0; in_valid = 1'b0;
    chk("abort_outputs", outs_ones(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 100 && fft_busy; c++) begin
      if (cmd_ready) bad++;
      @(negedge clk);
    end
    chk("abort_cmd_ready_while_busy", bad, 0);
    chk("abort_busy_fell", fft_busy, 0);
    chk("abort_cmd_ready_after", cmd_ready, 1);
    chk("abort_no_frame_done", n_done - d0, 0);
    chk("abort_no_beats", n_beats - b0, 0);

`ifdef FFT_TIMEOUT_EN
    // 6: core never completes; watchdog fires in the 256th COMPUTE cycle
    never_done = 1'b1; d0 = n_done;
    cmd_valid = 1'b1; cmd_inv = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0; in_valid = 1'b1; in_re = 16'd1;
    for (int c = 0; c < 1000 && !to_seen; c++) @(negedge clk);
    in_valid = 1'b0;
    chk("to_seen", to_seen, 1);
    chk("to_cycle", to_cyc - last_inrdy_cyc, 256);
    repeat (3) @(negedge clk);
    chk("to_sticky", timeout, 1);
    chk("to_no_frame_done", n_done - d0, 0);
    chk("to_out_valid", out_valid, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
Sequencer for the 128-point burst-mode FFT core (fftip). It accepts a per-frame direction command, configures the core's direction, and streams one frame of samples into the core. It then waits for completion, issues unload and forwards results as a registered output stream. It replaces bench-style manual driving of start/unload/fwd_inv with a single synthesizable controller between the sample source and the result sink.

Parameters:
NFFT_LOG2, 7, log2 of transform length; N = 2**NFFT_LOG2 points per frame.
IN_W, 16, width of each input real/imag sample.
OUT_W, 24, width of each output real/imag bin.
TIMEOUT_CYC, 4096, watchdog limit in cycles (used only with FFT_TIMEOUT_EN).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  synchronous active-low reset.
cmd_valid / cmd_ready  in/out  1/1  frame command handshake.
cmd_inv  in  1  0 = forward, 1 = inverse; latched on command accept.
in_valid / in_ready  in/out  1/1  input sample handshake.
in_re, in_im  in  IN_W  input sample.
out_valid  out  1  result beat valid. No backpressure; the sink must accept every beat.
out_last  out  1  marks bin N-1.
out_index  out  NFFT_LOG2  bin index.
out_re, out_im  out  OUT_W  result bin.
frame_done  out  1  one-cycle pulse after out_last.
underrun  out  1  sticky: a sample was missing during LOAD.
timeout  out  1  sticky watchdog flag; tied 0 when the macro is undefined.
fft_start, fft_unload, fft_fwd_inv, fft_fwd_inv_we  out  1 each  core controls.
fft_xn_re, fft_xn_im  out  IN_W  core input sample.
fft_rfd, fft_busy, fft_done, fft_edone, fft_dv  in  1 each  core status.
fft_xn_index, fft_xk_index  in  NFFT_LOG2  core indices.
fft_xk_re, fft_xk_im  in  OUT_W  core output bin.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; every output, both counters and both sticky flags go to 0.
- After reset the core may still be mid-frame, because it has no reset of its own. cmd_ready = (state==IDLE) && !fft_busy.
- IDLE: on cmd_valid&&cmd_ready, latch inv = cmd_inv, clear underrun and timeout, go to CONFIG.
- CONFIG (1 cycle): fft_fwd_inv_we=1 and fft_fwd_inv=!inv (1 = forward). Go to LOAD.
- LOAD:
  - fft_start=1 in the first LOAD cycle only.
  - in_ready = fft_rfd.
  - On each fft_rfd cycle: if in_valid, drive fft_xn_* = in_*; otherwise drive 0 and set underrun.
  - The load counter counts fft_rfd cycles. When count N-1 is reached with fft_rfd high, go to COMPUTE.
  - fft_xn_* are combinational from in_* so the core samples them in the same cycle.
- COMPUTE: wait for fft_done (fft_edone is ignored). Go to UNLOAD.
- UNLOAD (1 cycle): fft_unload=1. Go to DRAIN.
- DRAIN:
  - On fft_dv, out_* are registered from fft_xk_* with 1-cycle latency; out_index = fft_xk_index.
  - The drain counter counts fft_dv cycles. out_last=1 on beat N-1.
  - On the cycle after the out_last beat: frame_done=1, state returns to IDLE.
- cmd_valid in any non-IDLE state is not accepted; cmd_ready stays 0.
- Counters wrap from N-1 to 0. Each counter is cleared on entry to its state.
- A reset asserted in any state returns the controller to IDLE on that edge. Any partial frame is abandoned and no frame_done is produced.

Optional Feature:
- FFT_TIMEOUT_EN defined:
  - A watchdog counter runs in COMPUTE and in DRAIN, and is cleared on each state entry.
  - On reaching TIMEOUT_CYC: set timeout, deassert out_valid, go to IDLE, no frame_done.
- FFT_TIMEOUT_EN undefined: no watchdog logic; timeout is a constant 0.

Decomposition:
- Package fft_ctrl_pkg holds:
  - the state enum (IDLE, CONFIG, LOAD, COMPUTE, UNLOAD, DRAIN);
  - the constant N derived from NFFT_LOG2;
  - the encoding constant FWD=1 for fft_fwd_inv.
- One sub-module, fft_idx_counter: a NFFT_LOG2-bit counter with clear, enable and a terminal-count flag. It is instantiated twice, once for load and once for drain.

Test Plan:
1. Hold rst_n=0 for 5 cycles. Required: all outputs 0 and state IDLE. After release with the core model idle, cmd_ready=1 on the next cycle.
2. Forward frame: cmd_inv=0, then 128 contiguous samples with in_re=1, in_im=0. Required:
   - fft_fwd_inv_we pulses 1 cycle with fft_fwd_inv=1, and fft_start pulses 1 cycle;
   - in_ready is high for exactly 128 cycles;
   - fft_unload pulses 1 cycle after fft_done;
   - exactly 128 out_valid beats follow, with out_last on out_index 127 and out_re at index 0 equal to the model's DC value (128 unscaled);
   - frame_done pulses once and underrun=0.
3. Underrun: in_valid is low for samples 40-42. Required: zeros are driven at fft_xn_index 40-42, underrun=1, and the frame still yields 128 output beats.
4. Inverse command accepted immediately after frame_done. Required: fft_fwd_inv=0 during CONFIG. A cmd_valid pulse issued during DRAIN is ignored (cmd_ready=0).
5. Assert rst_n=0 at load sample 64 while the core model stays busy for 50 more cycles. Required: all outputs 0, and cmd_ready=0 until fft_busy falls.
6. With FFT_TIMEOUT_EN defined and TIMEOUT_CYC=256, the model never asserts fft_done. Required: timeout=1 in the 256th COMPUTE cycle, return to IDLE, no frame_done.
